// File: rtl/fft8_pkg.sv
// Shared types and constants for the 8-point FFT spectrogram path.
// Used by the frame sequencer, the FFT datapath top and the display writer.
package fft8_pkg;

   localparam int unsigned DW    = 12;
   localparam int unsigned NPTS  = 8;
   localparam int unsigned BIN_W = 3;

   typedef enum logic [1:0] {
      InFill,
      InSettle,
      InHold
   } in_state_t;

   typedef enum logic {
      OutIdle,
      OutDrain
   } out_state_t;

endpackage

// File: rtl/fft8_mag_serializer.sv
// Captures the 8 FFT bin magnitudes and streams them out one bin per handshake.
// Owns the output buffer, read pointer, output FSM and the drained-frame counter.
module fft8_mag_serializer
   import fft8_pkg::*;
#(
   parameter int unsigned DW        = fft8_pkg::DW,
   parameter int unsigned MAG_SHIFT = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 capture,
   input  logic [NPTS*DW-1:0]   mag_bus,
   output logic                 free,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [DW-1:0]        m_data,
   output logic [BIN_W-1:0]     m_bin,
   output logic                 m_last,
   output logic [15:0]          frame_cnt
);

   out_state_t            state;
   logic [NPTS*DW-1:0]    out_buf;
   logic [BIN_W-1:0]      rd_ptr;
   logic [DW-1:0]         cur_mag;
   logic                  hs;

   // Every output is a pure function of registered state, so it cannot move
   // while the display side stalls.
   assign cur_mag = out_buf[rd_ptr*DW +: DW];
   assign m_data  = cur_mag >> MAG_SHIFT;
   assign m_valid = (state == OutDrain);
   assign m_bin   = rd_ptr;
   assign m_last  = (rd_ptr == BIN_W'(NPTS - 1));
   assign hs      = m_valid && m_ready;

   // A new frame may be loaded when idle, or in the cycle the final bin leaves.
   assign free = !m_valid || (hs && m_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= OutIdle;
         out_buf   <= '0;
         rd_ptr    <= '0;
         frame_cnt <= '0;
      end else if (flush) begin
         state  <= OutIdle;
         rd_ptr <= '0;
      end else begin
         if (hs) begin
            rd_ptr <= rd_ptr + BIN_W'(1);
            if (m_last) begin
               frame_cnt <= frame_cnt + 16'd1;
               state     <= OutIdle;
            end
         end
         if (capture) begin
            out_buf <= mag_bus;
            rd_ptr  <= '0;
            state   <= OutDrain;
         end
      end
   end

endmodule

// File: rtl/fft8_frame_sequencer.sv
// Collects 8-sample frames for the combinational FFT, waits for it to settle,
// then hands the bin magnitudes to the serializer for the display side.
module fft8_frame_sequencer
   import fft8_pkg::*;
#(
   parameter int unsigned DW        = fft8_pkg::DW,
   parameter int unsigned SETTLE    = 2,
   parameter int unsigned MAG_SHIFT = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [DW-1:0]        s_data,
   output logic [NPTS*DW-1:0]   fft_in,
   input  logic [NPTS*DW-1:0]   fft_mag,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [DW-1:0]        m_data,
   output logic [BIN_W-1:0]     m_bin,
   output logic                 m_last,
   output logic [15:0]          frame_cnt
);

   localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   in_state_t          in_state;
   logic [CW-1:0]      settle_cnt;
   logic [BIN_W-1:0]   wr_ptr;
   logic               s_hs;
   logic               ser_free;
   logic               capture;

   assign s_hs    = s_valid && s_ready;
   assign capture = (in_state == InHold) && ser_free && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_state   <= InFill;
         settle_cnt <= '0;
         wr_ptr     <= '0;
         fft_in     <= '0;
         s_ready    <= 1'b0;
      end else if (flush) begin
         in_state   <= InFill;
         settle_cnt <= '0;
         wr_ptr     <= '0;
         s_ready    <= 1'b1;
      end else begin
         case (in_state)
            InFill: begin
               s_ready <= 1'b1;
               if (s_hs) begin
                  fft_in[wr_ptr*DW +: DW] <= s_data;
                  wr_ptr                  <= wr_ptr + BIN_W'(1);
                  if (wr_ptr == BIN_W'(NPTS - 1)) begin
                     in_state   <= InSettle;
                     settle_cnt <= '0;
                     s_ready    <= 1'b0;
                  end
               end
            end
            InSettle: begin
               if (settle_cnt == CW'(SETTLE - 1)) begin
                  in_state <= InHold;
               end else begin
                  settle_cnt <= settle_cnt + CW'(1);
               end
            end
            InHold: begin
               // fft_in stays frozen here until the serializer can take the bins.
               if (capture) begin
                  in_state <= InFill;
                  s_ready  <= 1'b1;
               end
            end
            default: begin
               in_state <= InFill;
               s_ready  <= 1'b0;
            end
         endcase
      end
   end

   fft8_mag_serializer #(
      .DW        (DW),
      .MAG_SHIFT (MAG_SHIFT)
   ) u_serializer (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .capture   (capture),
      .mag_bus   (fft_mag),
      .free      (ser_free),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_bin     (m_bin),
      .m_last    (m_last),
      .frame_cnt (frame_cnt)
   );

endmodule

// File: tb/tb_fft8_frame_sequencer.sv
// Directed bench for fft8_frame_sequencer with a constant stub FFT (bin k = 100+k).
module tb_fft8_frame_sequencer;

   localparam int DW     = 12;
   localparam int SETTLE = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              flush;
   logic              s_valid;
   logic              s_ready;
   logic [DW-1:0]     s_data;
   logic [8*DW-1:0]   fft_in;
   logic [8*DW-1:0]   fft_mag;
   logic              m_valid;
   logic              m_ready;
   logic [DW-1:0]     m_data;
   logic [2:0]        m_bin;
   logic              m_last;
   logic [15:0]       frame_cnt;

   typedef struct {
      logic [DW-1:0] sample;
      logic [DW-1:0] mag;
   } vec_t;

   vec_t          basic[8];
   logic [DW-1:0] frame[8];
   int            tests = 0;
   int            fails = 0;
   int            exp_frames = 0;

   fft8_frame_sequencer #(
      .DW        (DW),
      .SETTLE    (SETTLE),
      .MAG_SHIFT (0)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .fft_in    (fft_in),
      .fft_mag   (fft_mag),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_bin     (m_bin),
      .m_last    (m_last),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed_n(input int n);
      for (int i = 0; i < n; i++) begin
         int w;
         s_valid = 1'b1;
         s_data  = frame[i];
         w = 0;
         while (!s_ready && w < 50) begin
            tick();
            w++;
         end
         if (!s_ready) check($sformatf("feed_ready_timeout%0d", i), 32'(s_ready), 32'd1);
         tick();
      end
      s_valid = 1'b0;
   endtask

   task automatic check_fft_in(input string tag);
      for (int i = 0; i < 8; i++)
         check($sformatf("%s_slot%0d", tag, i), 32'(fft_in[i*DW +: DW]), 32'(frame[i]));
   endtask

   task automatic wait_valid(input string tag, input int exp_cyc);
      int cyc;
      cyc = 0;
      while (!m_valid && cyc < 40) begin
         tick();
         cyc++;
      end
      check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
   endtask

   task automatic drain(input string tag, input int stall_bin, input int stall_len,
                        input logic next_valid);
      m_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         check($sformatf("%s_valid%0d", tag, k), 32'(m_valid), 32'd1);
         check($sformatf("%s_bin%0d", tag, k), 32'(m_bin), 32'(k));
         check($sformatf("%s_data%0d", tag, k), 32'(m_data), 32'(basic[k].mag));
         check($sformatf("%s_last%0d", tag, k), 32'(m_last), 32'(k == 7));
         if (k == stall_bin) begin
            m_ready = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               tick();
               check($sformatf("%s_stall_valid%0d", tag, s), 32'(m_valid), 32'd1);
               check($sformatf("%s_stall_bin%0d", tag, s), 32'(m_bin), 32'(k));
               check($sformatf("%s_stall_data%0d", tag, s), 32'(m_data), 32'(basic[k].mag));
            end
            m_ready = 1'b1;
         end
         tick();
      end
      exp_frames++;
      check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
      check({tag, "_end_valid"}, 32'(m_valid), 32'(next_valid));
   endtask

   initial begin
      int accepted, outs, lows, ovl;

      basic[0] = '{12'(10),  12'd100};
      basic[1] = '{12'(5),   12'd101};
      basic[2] = '{12'(-10), 12'd102};
      basic[3] = '{12'(12),  12'd103};
      basic[4] = '{12'(-15), 12'd104};
      basic[5] = '{12'(14),  12'd105};
      basic[6] = '{12'(0),   12'd106};
      basic[7] = '{12'(-9),  12'd107};
      for (int k = 0; k < 8; k++) fft_mag[k*DW +: DW] = 12'(100 + k);

      rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_m_bin", 32'(m_bin), 32'd0);
      check("rst_m_last", 32'(m_last), 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check("rst_fft_in_lo", fft_in[31:0], 32'd0);
      rst_n = 1'b1;
      tick();
      check("post_rst_s_ready", 32'(s_ready), 32'd1);

      // Basic frame from the vector table
      for (int i = 0; i < 8; i++) frame[i] = basic[i].sample;
      feed_n(8);
      check("basic_s_ready_settle", 32'(s_ready), 32'd0);
      check_fft_in("basic");
      wait_valid("basic", SETTLE + 1);
      drain("basic", -1, 0, 1'b0);

      // Backpressure at bin 3
      for (int i = 0; i < 8; i++) frame[i] = 12'(300 + i);
      feed_n(8);
      wait_valid("bp", SETTLE + 1);
      drain("bp", 3, 5, 1'b0);

      // Three frames offered back to back
      accepted = 0; outs = 0; lows = 0; ovl = 0;
      m_ready = 1'b1;
      for (int cyc = 0; cyc < 300 && outs < 24; cyc++) begin
         s_valid = (accepted < 24);
         s_data  = 12'(200 + accepted);
         if (s_valid && !s_ready) lows++;
         if (s_valid && s_ready && m_valid) ovl++;
         if (m_valid) begin
            check($sformatf("ovl_bin%0d", outs), 32'(m_bin), 32'(outs % 8));
            check($sformatf("ovl_data%0d", outs), 32'(m_data), 32'(100 + outs % 8));
            check($sformatf("ovl_last%0d", outs), 32'(m_last), 32'(outs % 8 == 7));
            outs++;
         end
         if (s_valid && s_ready) accepted++;
         tick();
      end
      s_valid = 1'b0;
      exp_frames += 3;
      check("ovl_outs", 32'(outs), 32'd24);
      check("ovl_fill_during_drain", 32'(ovl), 32'd16);
      check("ovl_s_ready_low", 32'(lows), 32'(2 * (SETTLE + 1)));
      check("ovl_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
      check("ovl_end_valid", 32'(m_valid), 32'd0);
      for (int i = 0; i < 8; i++) frame[i] = 12'(216 + i);
      check_fft_in("ovl");

      // Second frame parks in HOLD behind a stalled output
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) frame[i] = 12'(1 + i);
      feed_n(8);
      wait_valid("busyA", SETTLE + 1);
      for (int i = 0; i < 8; i++) frame[i] = 12'(21 + i);
      feed_n(8);
      repeat (SETTLE) tick();
      for (int c = 0; c < 6; c++) begin
         check($sformatf("hold_s_ready%0d", c), 32'(s_ready), 32'd0);
         check($sformatf("hold_m_bin%0d", c), 32'(m_bin), 32'd0);
         tick();
      end
      check_fft_in("hold");
      drain("busyA", -1, 0, 1'b1);
      check("busy_capture_bin", 32'(m_bin), 32'd0);
      check("busy_capture_s_ready", 32'(s_ready), 32'd1);
      drain("busyB", -1, 0, 1'b0);

      // Flush after 5 samples
      for (int i = 0; i < 8; i++) frame[i] = 12'(30 + i);
      feed_n(5);
      s_valid = 1'b1; s_data = 12'h077; flush = 1'b1;
      tick();
      flush = 1'b0; s_valid = 1'b0;
      check("flush_m_valid", 32'(m_valid), 32'd0);
      check("flush_s_ready", 32'(s_ready), 32'd1);
      check("flush_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
      for (int i = 0; i < 8; i++) frame[i] = 12'(50 + i);
      feed_n(8);
      check_fft_in("flush");
      wait_valid("flush", SETTLE + 1);
      check("flush_frame_cnt2", 32'(frame_cnt), 32'(exp_frames));
      drain("flush", -1, 0, 1'b0);

      // Async reset mid-drain at bin 4
      for (int i = 0; i < 8; i++) frame[i] = 12'(60 + i);
      feed_n(8);
      wait_valid("arst", SETTLE + 1);
      m_ready = 1'b1;
      repeat (4) tick();
      check("arst_pre_bin", 32'(m_bin), 32'd4);
      rst_n = 1'b0;
      #2;
      check("arst_m_valid", 32'(m_valid), 32'd0);
      check("arst_m_bin", 32'(m_bin), 32'd0);
      check("arst_m_last", 32'(m_last), 32'd0);
      check("arst_m_data", 32'(m_data), 32'd0);
      check("arst_s_ready", 32'(s_ready), 32'd0);
      check("arst_frame_cnt", 32'(frame_cnt), 32'd0);
      check("arst_fft_in_lo", fft_in[31:0], 32'd0);
      #10;
      rst_n = 1'b1;
      tick();
      check("arst_rel_s_ready", 32'(s_ready), 32'd1);
      check("arst_rel_frame_cnt", 32'(frame_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
